// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one byte-wide RAM between a CPU
// memory-stage port (c_*) and a loader/debug port (l_*).
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   c_req_i/c_we_i        CPU request and write-enable
//   c_addr_i/c_wdata_i    CPU 64-bit byte address and write data
//   c_ack_o/c_err_o       CPU one-cycle completion pulse and address error
//   c_rdata_o/c_stall_o   CPU read data (with ack) and pipeline stall
//   l_*                   loader port, same meaning as the CPU port
//   mem_en_o/mem_we_o     RAM access strobe and byte write
//   mem_addr_o            RAM byte address
//   mem_wdata_o           RAM write byte
//   mem_rdata_i           RAM read byte, one cycle after a read strobe
//
// Each transfer moves 8 bytes little-endian, one byte per cycle.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        c_req_i,
    input  logic        c_we_i,
    input  logic [63:0] c_addr_i,
    input  logic [63:0] c_wdata_i,
    output logic        c_ack_o,
    output logic        c_err_o,
    output logic [63:0] c_rdata_o,
    output logic        c_stall_o,

    input  logic        l_req_i,
    input  logic        l_we_i,
    input  logic [63:0] l_addr_i,
    input  logic [63:0] l_wdata_i,
    output logic        l_ack_o,
    output logic        l_err_o,
    output logic [63:0] l_rdata_o,

    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [9:0]  mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        CAPTURE,
        DONE
    } state_t;

    // Highest base address whose 8-byte window still fits in the RAM.
    localparam logic [63:0] LAST_BASE = 64'(MEM_BYTES) - 64'd8;

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  beat_q;
    logic        sel_q;      // winner of the current transfer: 1 = loader
    logic        last_l_q;   // last grant went to the loader
    logic        we_q;
    logic        err_q;
    logic [9:0]  addr_q;
    logic [63:0] wdata_q;
    logic [63:0] rbuf_q;

    logic        any_req;
    logic        pick_l;
    logic        g_we;
    logic [63:0] g_addr;
    logic [63:0] g_wdata;
    logic        g_err;
    logic [2:0]  prev_beat;
    logic        done;

    // Grant selection: a lone requester wins, on contention the port
    // that was not granted last wins.
    always_comb begin
        any_req = c_req_i | l_req_i;
        pick_l  = l_req_i & (~c_req_i | ~last_l_q);
        g_we    = pick_l ? l_we_i    : c_we_i;
        g_addr  = pick_l ? l_addr_i  : c_addr_i;
        g_wdata = pick_l ? l_wdata_i : c_wdata_i;
        g_err   = g_addr > LAST_BASE;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = g_err ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (beat_q == 3'd7) begin
                    state_d = we_q ? DONE : CAPTURE;
                end
            end
            CAPTURE: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from state so an asynchronous reset clears
    // them immediately.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 10'd0;
        mem_wdata_o = 8'd0;
        if (state_q == ACCESS) begin
            mem_en_o    = 1'b1;
            mem_we_o    = we_q;
            mem_addr_o  = addr_q + {7'd0, beat_q};
            mem_wdata_o = wdata_q[{beat_q, 3'b000} +: 8];
        end
    end

    always_comb begin
        done      = (state_q == DONE);
        c_ack_o   = done & ~sel_q;
        l_ack_o   = done & sel_q;
        c_err_o   = c_ack_o & err_q;
        l_err_o   = l_ack_o & err_q;
        c_rdata_o = (c_ack_o & ~err_q & ~we_q) ? rbuf_q : 64'd0;
        l_rdata_o = (l_ack_o & ~err_q & ~we_q) ? rbuf_q : 64'd0;
        c_stall_o = c_req_i & ~c_ack_o;
    end

    // Byte returned for the previous beat's read strobe.
    assign prev_beat = beat_q - 3'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            beat_q   <= 3'd0;
            sel_q    <= 1'b0;
            last_l_q <= 1'b1;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= 10'd0;
            wdata_q  <= 64'd0;
            rbuf_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        sel_q    <= pick_l;
                        last_l_q <= pick_l;
                        we_q     <= g_we;
                        err_q    <= g_err;
                        addr_q   <= g_addr[9:0];
                        wdata_q  <= g_wdata;
                        beat_q   <= 3'd0;
                        rbuf_q   <= 64'd0;
                    end
                end
                ACCESS: begin
                    beat_q <= beat_q + 3'd1;
                    if (!we_q && beat_q != 3'd0) begin
                        rbuf_q[{prev_beat, 3'b000} +: 8] <= mem_rdata_i;
                    end
                end
                CAPTURE: begin
                    rbuf_q[63:56] <= mem_rdata_i;
                end
                DONE: begin
                    beat_q <= 3'd0;
                end
                default: begin
                    beat_q <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors and corner sequences for dmem_arbiter,
// with a behavioural byte RAM attached to the mem_* port.
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        c_req_i, c_we_i;
    logic [63:0] c_addr_i, c_wdata_i;
    logic        c_ack_o, c_err_o, c_stall_o;
    logic [63:0] c_rdata_o;
    logic        l_req_i, l_we_i;
    logic [63:0] l_addr_i, l_wdata_i;
    logic        l_ack_o, l_err_o;
    logic [63:0] l_rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;

    dmem_arbiter #(.MEM_BYTES(1024)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c_req_i(c_req_i), .c_we_i(c_we_i),
        .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
        .c_ack_o(c_ack_o), .c_err_o(c_err_o),
        .c_rdata_o(c_rdata_o), .c_stall_o(c_stall_o),
        .l_req_i(l_req_i), .l_we_i(l_we_i),
        .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i),
        .l_ack_o(l_ack_o), .l_err_o(l_err_o), .l_rdata_o(l_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural RAM: synchronous write, registered read.
    logic [7:0] ram [0:1023];
    logic       ram_clr = 1'b1;
    always @(posedge clk_i) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
            mem_rdata_i <= 8'h00;
        end else if (mem_en_o) begin
            if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
            else          mem_rdata_i <= ram[mem_addr_o];
        end
    end

    function automatic logic [63:0] word_at(input int a);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = ram[a + k];
        return w;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Continuous protocol monitor.
    int proto_bad = 0;
    int en_count  = 0;
    int lack_count = 0;
    always @(negedge clk_i) begin
        if (!mem_en_o && (mem_we_o || mem_addr_o != 0 || mem_wdata_o != 0))
            proto_bad++;
        if (!c_ack_o && (c_err_o || c_rdata_o != 0)) proto_bad++;
        if (!l_ack_o && (l_err_o || l_rdata_o != 0)) proto_bad++;
        if (c_ack_o && l_ack_o) proto_bad++;
        if (c_stall_o !== (c_req_i & ~c_ack_o)) proto_bad++;
        if (mem_en_o) en_count++;
        if (l_ack_o) lack_count++;
    end

    // One transfer on one port; latency counts cycles from the cycle in
    // which req is first seen (cycle 1) to the ack cycle.
    task automatic xfer(input logic port, input logic we,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        output int lat, output logic err,
                        output logic [63:0] rdata, output int stall_bad);
        logic got;
        got = 1'b0;
        lat = -1;
        err = 1'b0;
        rdata = '0;
        stall_bad = 0;
        @(posedge clk_i); #1;
        if (port) begin
            l_req_i = 1'b1; l_we_i = we;
            l_addr_i = addr; l_wdata_i = wdata;
        end else begin
            c_req_i = 1'b1; c_we_i = we;
            c_addr_i = addr; c_wdata_i = wdata;
        end
        for (int n = 1; n <= 40 && !got; n++) begin
            @(negedge clk_i);
            if (port ? l_ack_o : c_ack_o) begin
                got = 1'b1;
                lat = n;
                err = port ? l_err_o : c_err_o;
                rdata = port ? l_rdata_o : c_rdata_o;
                if (!port && c_stall_o) stall_bad++;
            end else if (!port && !c_stall_o) begin
                stall_bad++;
            end
        end
        @(posedge clk_i); #1;
        c_req_i = 1'b0;
        l_req_i = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        port;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        err;
        logic [63:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int          lat;
        logic        err;
        logic [63:0] rdata;
        int          sbad;
        int          en0;
        int          l0;
        int          nack;
        int          first_lat;
        int          second_lat;
        logic [2:0]  ord;
        logic [63:0] r_first;
        logic [63:0] r_second;

        vecs[0] = '{"c_wr_10", 0, 1, 64'h10, 64'h1122334455667788,
                    0, 64'h0, 10};
        vecs[1] = '{"c_rd_10", 0, 0, 64'h10, 64'h0,
                    0, 64'h1122334455667788, 11};
        vecs[2] = '{"l_wr_100", 1, 1, 64'h100, 64'hA5A5010203040506,
                    0, 64'h0, 10};
        vecs[3] = '{"l_rd_100", 1, 0, 64'h100, 64'h0,
                    0, 64'hA5A5010203040506, 11};
        vecs[4] = '{"c_wr_1016", 0, 1, 64'd1016, 64'hDEADBEEFCAFEF00D,
                    0, 64'h0, 10};
        vecs[5] = '{"c_rd_1016", 0, 0, 64'd1016, 64'h0,
                    0, 64'hDEADBEEFCAFEF00D, 11};
        vecs[6] = '{"c_rd_1017", 0, 0, 64'd1017, 64'h0,
                    1, 64'h0, 2};
        vecs[7] = '{"c_wr_4g", 0, 1, 64'h1_0000_0000, 64'h1234,
                    1, 64'h0, 2};
        vecs[8] = '{"l_rd_1020", 1, 0, 64'd1020, 64'h0,
                    1, 64'h0, 2};
        vecs[9] = '{"c_rd_13", 0, 0, 64'h13, 64'h0,
                    0, 64'h0000001122334455, 11};

        rst_i = 1'b1;
        c_req_i = 0; c_we_i = 0; c_addr_i = 0; c_wdata_i = 0;
        l_req_i = 0; l_we_i = 0; l_addr_i = 0; l_wdata_i = 0;
        repeat (3) @(posedge clk_i);
        ram_clr = 1'b0;
        @(negedge clk_i);
        chk("rst_outputs",
            {c_ack_o, l_ack_o, c_err_o, l_err_o, mem_en_o, mem_we_o},
            64'h0);
        chk("rst_data", c_rdata_o | l_rdata_o |
            {46'd0, mem_addr_o, mem_wdata_o}, 64'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            en0 = en_count;
            xfer(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 lat, err, rdata, sbad);
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
            chk({vecs[i].name, "_err"}, 64'(err), 64'(vecs[i].err));
            chk({vecs[i].name, "_rdata"}, rdata, vecs[i].rdata);
            chk({vecs[i].name, "_ram_beats"}, 64'(en_count - en0),
                vecs[i].err ? 64'd0 : 64'd8);
            if (!vecs[i].port)
                chk({vecs[i].name, "_stall"}, 64'(sbad), 64'd0);
            if (i == 0)
                chk("ram_word_10", word_at(16), 64'h1122334455667788);
            if (i == 4)
                chk("ram_word_1016", word_at(1016), 64'hDEADBEEFCAFEF00D);
        end

        // Contention right after reset: CPU first, then alternate.
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        c_req_i = 1; c_we_i = 0; c_addr_i = 64'h10;
        l_req_i = 1; l_we_i = 0; l_addr_i = 64'h100;
        nack = 0; ord = 3'b000;
        first_lat = -1; second_lat = -1;
        r_first = '0; r_second = '0;
        for (int n = 1; n <= 100 && nack < 3; n++) begin
            @(negedge clk_i);
            if (c_ack_o || l_ack_o) begin
                ord = {ord[1:0], l_ack_o};
                if (nack == 0) begin
                    first_lat = n;
                    r_first = c_rdata_o | l_rdata_o;
                end
                if (nack == 1) begin
                    second_lat = n;
                    r_second = c_rdata_o | l_rdata_o;
                end
                nack++;
            end
        end
        @(posedge clk_i); #1;
        c_req_i = 0; l_req_i = 0;
        chk("rr_ack_count", 64'(nack), 64'd3);
        chk("rr_order_clc", 64'(ord), 64'b010);
        chk("rr_first_lat", 64'(first_lat), 64'd11);
        chk("rr_second_lat", 64'(second_lat), 64'd22);
        chk("rr_first_rdata", r_first, 64'h1122334455667788);
        chk("rr_second_rdata", r_second, 64'hA5A5010203040506);

        // Reset in the middle of a loader write.
        @(posedge clk_i); #1;
        l0 = lack_count;
        l_req_i = 1; l_we_i = 1;
        l_addr_i = 64'h200; l_wdata_i = 64'hFFEEDDCCBBAA9988;
        repeat (6) @(negedge clk_i);
        chk("abort_at_beat4", {54'd0, mem_addr_o}, 64'h204);
        rst_i = 1'b1;
        #1;
        chk("abort_outputs_zero",
            {l_ack_o, l_err_o, mem_en_o, mem_we_o, mem_addr_o,
             mem_wdata_o}, 64'h0);
        @(posedge clk_i); #1;
        l_req_i = 0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        chk("abort_no_ack", 64'(lack_count - l0), 64'd0);
        chk("abort_ram_kept", word_at(512), 64'h00000000BBAA9988);
        xfer(1'b0, 1'b0, 64'h200, 64'h0, lat, err, rdata, sbad);
        chk("post_abort_lat", 64'(lat), 64'd11);
        chk("post_abort_rdata", rdata, 64'h00000000BBAA9988);
        chk("post_abort_err", 64'(err), 64'd0);

        chk("protocol_monitor", 64'(proto_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL change on the rising clock edge except at reset.
REQ-002 Ports (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- c_req_i  in  1  CPU memory-stage request
- c_we_i  in  1  CPU write (1) / read (0)
- c_addr_i  in  64  CPU byte address
- c_wdata_i  in  64  CPU write data
- c_ack_o  out  1  CPU transfer complete, one-cycle pulse
- c_err_o  out  1  CPU address error, valid with c_ack_o
- c_rdata_o  out  64  CPU read data, valid with c_ack_o
- c_stall_o  out  1  CPU stage stall
- l_req_i, l_we_i, l_addr_i[64], l_wdata_i[64]  in  loader/debug port, same meaning as the c_* inputs
- l_ack_o, l_err_o, l_rdata_o[64]  out  loader port, same meaning as the c_* outputs
- mem_en_o  out  1  RAM access strobe
- mem_we_o  out  1  RAM byte write
- mem_addr_o  out  10  RAM byte address
- mem_wdata_o  out  8  RAM write byte
- mem_rdata_i  in  8  RAM read byte, valid one cycle after the mem_en_o=1, mem_we_o=0 cycle
REQ-003 Parameter: MEM_BYTES, default 1024, the RAM size in bytes.

Function
REQ-004 The block SHALL share one byte-wide RAM between two 64-bit requesters; each transfer SHALL move 8 bytes, little-endian (byte k = data[8k+7:8k] at address base+k).
REQ-005 States SHALL be IDLE, ACCESS, CAPTURE and DONE.
REQ-006 IDLE: if any req is high, the block SHALL pick a winner and latch its we, addr and wdata. It SHALL then go to DONE if addr > MEM_BYTES-8, including any nonzero bits in [63:10]; otherwise it SHALL go to ACCESS with beat counter = 0.
REQ-007 Arbitration SHALL be round-robin. A single requester wins outright. When both request, the winner SHALL be the port not granted last. The last-grant pointer SHALL update on every grant.
REQ-008 ACCESS: mem_en_o SHALL be 1, mem_addr_o = base+beat, mem_we_o = latched we, and mem_wdata_o = byte beat of the latched wdata. The beat counter SHALL increment each cycle.
REQ-009 At beat 7 the next state SHALL be DONE for a write and CAPTURE for a read.
REQ-010 Read data: the byte returned by mem_rdata_i for beat k-1 SHALL be captured during beat k (k = 1..7); byte 7 SHALL be captured in CAPTURE. CAPTURE SHALL then go to DONE.
REQ-011 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-012 In DONE, the winner's ack_o SHALL be 1 and its err_o SHALL be 1 only for an address error.
REQ-013 Also in DONE, the winner's rdata_o SHALL hold the assembled read, or 0 for a write or an error.
REQ-014 The loser's ack_o SHALL stay 0.
REQ-015 Latency from the request-sampling edge: write ack in the 10th cycle, read ack in the 11th cycle, error ack in the 2nd cycle. An error transfer SHALL perform no RAM access.
REQ-016 Outside ACCESS, mem_en_o and mem_we_o SHALL be 0, and mem_addr_o and mem_wdata_o SHALL be 0.
REQ-017 A requester SHALL hold req and its operands stable until ack.
REQ-018 req still high in the cycle after ack SHALL be a new request. The block SHALL ignore operand changes after latching.
REQ-019 c_stall_o SHALL equal c_req_i AND NOT c_ack_o (combinational).
REQ-020 rdata_o and err_o SHALL be 0 whenever ack_o is 0.

Reset
REQ-021 While rst_i is high, the state SHALL be IDLE and the beat counter 0.
REQ-022 While rst_i is high, all ack, err, rdata and mem_* outputs SHALL be 0.
REQ-023 While rst_i is high, the last-grant pointer SHALL be set to loader, so the CPU wins the first contention.
REQ-024 Reset during ACCESS or CAPTURE SHALL abort the transfer with no ack. Bytes already written SHALL remain in RAM.
REQ-025 The RAM contents SHALL NOT be cleared by this block.

Verification
REQ-026 CPU write 0x1122334455667788 at addr 0x10 -> bytes 0x88..0x11 at 0x10..0x17 on mem_* in cycles 2-9; c_ack_o=1, c_err_o=0 in cycle 10.
REQ-027 CPU read at 0x10 after REQ-026 -> c_ack_o in cycle 11 with c_rdata_o=0x1122334455667788; c_stall_o high through cycle 10.
REQ-028 Both requesters read at reset exit -> CPU served first, loader served next. With both requests held, grants SHALL alternate C, L, C.
REQ-029 CPU request at addr 1017, and separately at 0x1_0000_0000 -> ack with c_err_o=1 in cycle 2; mem_en_o stays 0.
REQ-030 Address 1016 write -> succeeds, bytes at 1016..1023; no error.
REQ-031 Assert rst_i at beat 4 of a loader write -> no l_ack_o; outputs 0 immediately; the next CPU request is served normally.
